wb_arb2_timeout: RTL and testbench
==================================

Name: wb_arb2_timeout

Overview:
- Two-master, one-slave Wishbone classic arbiter with a bus-watchdog.
- Lets the UART bridge master and a second on-chip master (e.g. a coefficient loader) share the filter/register Wishbone bus.
- Grant is round-robin and held for the whole cyc_o tenure of the owner.
- A slave that never terminates a strobe is cut off with a generated error, so neither master can hang the bus.

Parameters:
ADDR_WIDTH, 22, width of address buses
DATA_WIDTH, 32, width of data buses (sel width = DATA_WIDTH/8)
TIMEOUT, 255, cycles a strobe may wait for ack/err/rty before a forced error (1..65535)

Ports:
wb_clk_i  in  1  bus clock
wb_rst_i  in  1  asynchronous active-high reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_dat_i  in  DATA_WIDTH  master 0 write data
m0_sel_i  in  DATA_WIDTH/8  master 0 byte selects
m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 termination
m0_dat_o  out  DATA_WIDTH  read data to master 0
m1_*  same set as m0_*  master 1
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel_o  out  DATA_WIDTH/8  slave byte selects
s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle
timeout_cnt_o  out  8  saturating count of forced errors

Behaviour:
- FSM states: IDLE, OWN0, OWN1. A registered last_owner bit exists.
- Reset (async, wb_rst_i=1):
  - state=IDLE, last_owner=1, so m0 wins the first tie.
  - wd counter=0, timeout_cnt_o=0, forced-err register=0.
  - All s_* control outputs and all m*_ack/err/rty outputs are 0.
- IDLE transitions:
  - Only m0_cyc_i=1 -> OWN0 next edge.
  - Only m1_cyc_i=1 -> OWN1 next edge.
  - Both high -> grant the master that is not last_owner.
  - last_owner updates on every grant.
- Request latency: cyc asserted in cycle N -> s_cyc_o first high in cycle N+1. There is no combinational grant.
- OWNx, owner keeps mx_cyc_i=1: stay in OWNx.
- OWNx, owner drops mx_cyc_i:
  - If the other master's cyc is high, move directly to OWNy at that edge. There are no idle cycles between tenures.
  - Otherwise move to IDLE.
- Slave-side outputs:
  - s_cyc_o = owner cyc & state!=IDLE. It is combinational from the registered state, so it drops in the same cycle the owner drops cyc.
  - s_stb_o = owner stb & s_cyc_o & !forced_err.
  - s_we/adr/dat/sel are muxed from the owner; in IDLE they come from m0.
- Master-side outputs:
  - m*_dat_o = s_dat_i broadcast to both masters.
  - ack/rty are routed only to the owner.
  - owner err = s_err_i | forced_err.
  - The non-owner sees ack/err/rty = 0 always.
- Watchdog:
  - The counter increments each cycle that s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
  - It clears on any termination, on s_stb_o=0, and on owner change.
  - When the counter reaches TIMEOUT-1 while still unterminated, forced_err is registered high for exactly one cycle. Err then reaches the owner TIMEOUT cycles after the strobe began.
  - During the forced_err cycle s_stb_o=0, so the slave sees the strobe withdrawn.
  - The counter clears, and timeout_cnt_o increments, saturating at 255.
  - If the slave acks in the same cycle forced_err is set, the ack passes through and forced_err is suppressed for that cycle. Exactly one termination is delivered: the ack.
- Owner abort: if the owner drops cyc mid-strobe, the transaction is abandoned. The watchdog clears, no err is generated, and the next-owner rules apply.
- Reset mid-transfer: all outputs go to their reset values immediately (async). A late s_ack_i after reset is ignored because no owner exists.
- grant_o reflects the registered state.

Test Plan:
- Single master: m0 write adr=0x000010 dat=0xDEADBEEF, slave acks 2 cycles after stb -> s_cyc_o high 1 cycle after m0_cyc_i, s_* mirror m0, m0_ack_o one cycle, m1_ack_o=0, grant_o=01 then 00.
- Simultaneous request from reset: m0_cyc_i and m1_cyc_i rise in the same cycle, each doing 3 reads -> m0 served first; m1 granted on the edge m0 drops cyc with zero idle cycles. Repeat the tie -> m1 first (round-robin).
- Held tenure: m1 owns and does 4 back-to-back strobes with cyc held while m0 requests -> m0 waits all 4; grant switches only after m1_cyc_i falls.
- Watchdog: TIMEOUT=16, slave never acks m0 read -> m0_err_o high exactly 16 cycles after stb, s_stb_o low that cycle, timeout_cnt_o=1. Repeat 300 times -> timeout_cnt_o saturates at 255.
- Ack/timeout collision: TIMEOUT=8, slave acks in the 8th cycle -> m0_ack_o=1, m0_err_o=0, timeout_cnt_o unchanged.
- Async reset mid-strobe while OWN1 -> s_cyc_o, s_stb_o, grant_o go to 0 without a clock edge; after release, m0/m1 tie grants m0.

Source files
------------

// File: rtl/wb_arb2_timeout.sv
// Two-master Wishbone classic arbiter: round-robin grant held per cyc tenure,
// with a watchdog that forces an error on strobes the slave never terminates.
module wb_arb2_timeout #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [1:0]              grant_o,
  output logic [7:0]              timeout_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  nxt;
  logic        last_owner;
  logic [15:0] wd;
  logic        forced_err;
  logic        own0;
  logic        own1;
  logic        term;
  logic        hit;
  logic        chg;
  logic        fe;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);
  assign grant_o = {own1, own0};

  assign s_cyc_o = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign s_stb_o = s_cyc_o & ~forced_err & (own1 ? m1_stb_i : m0_stb_i);
  assign s_we_o  = own1 ? m1_we_i  : m0_we_i;
  assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;
  assign s_sel_o = own1 ? m1_sel_i : m0_sel_i;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // A late slave ack wins over the forced error; an abandoned strobe gets none
  assign fe = forced_err & s_cyc_o & ~s_ack_i;

  assign m0_ack_o = own0 & s_ack_i;
  assign m0_rty_o = own0 & s_rty_i;
  assign m0_err_o = own0 & (s_err_i | fe);
  assign m1_ack_o = own1 & s_ack_i;
  assign m1_rty_o = own1 & s_rty_i;
  assign m1_err_o = own1 & (s_err_i | fe);

  assign term = s_ack_i | s_err_i | s_rty_i;
  assign hit  = s_stb_o & ~term & (wd == WD_MAX);
  assign chg  = (nxt != state);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner))
          nxt = OWN0;
        else if (m1_cyc_i)
          nxt = OWN1;
      end
      OWN0: if (!m0_cyc_i) nxt = m1_cyc_i ? OWN1 : IDLE;
      OWN1: if (!m1_cyc_i) nxt = m0_cyc_i ? OWN0 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      wd            <= '0;
      forced_err    <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      state <= nxt;
      if (chg && nxt == OWN0)
        last_owner <= 1'b0;
      else if (chg && nxt == OWN1)
        last_owner <= 1'b1;
      if (chg || !s_stb_o || term || hit)
        wd <= '0;
      else
        wd <= wd + 16'd1;
      forced_err <= hit;
      if (hit && timeout_cnt_o != 8'hFF)
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_arb2_timeout.sv
// Directed bench for wb_arb2_timeout: per-cycle vector table for arbitration,
// hand sequences for watchdog, ack/timeout collision and async reset.
module tb_wb_arb2_timeout;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam logic [AW-1:0] M0_ADR = 22'h000010;
  localparam logic [AW-1:0] M1_ADR = 22'h3ABCDE;
  localparam logic [DW-1:0] M0_DAT = 32'hDEADBEEF;
  localparam logic [DW-1:0] M1_DAT = 32'h12345678;
  localparam logic [DW-1:0] RD_DAT = 32'hCAFEF00D;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat;
  logic [3:0]    m0_sel;
  logic          m0_ack, m0_err, m0_rty;
  logic [DW-1:0] m0_rdat;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat;
  logic [3:0]    m1_sel;
  logic          m1_ack, m1_err, m1_rty;
  logic [DW-1:0] m1_rdat;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat;
  logic [3:0]    s_sel;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_rdat;
  logic [1:0]    grant;
  logic [7:0]    tcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arb2_timeout #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb),
    .m0_we_i(m0_we),
    .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat),
    .m0_sel_i(m0_sel),
    .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m0_rty_o(m0_rty),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb),
    .m1_we_i(m1_we),
    .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat),
    .m1_sel_i(m1_sel),
    .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .m1_rty_o(m1_rty),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc),
    .s_stb_o(s_stb),
    .s_we_o(s_we),
    .s_adr_o(s_adr),
    .s_dat_o(s_wdat),
    .s_sel_o(s_sel),
    .s_ack_i(s_ack),
    .s_err_i(s_err),
    .s_rty_i(s_rty),
    .s_dat_i(s_rdat),
    .grant_o(grant),
    .timeout_cnt_o(tcnt)
  );

  typedef struct {
    logic       m0c, m0s, m1c, m1s, ack;
    logic       ecyc, estb, ea0, ea1;
    logic [1:0] egnt;
    logic       esel1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic m0c, m0s, m1c, m1s, ack,
    input logic ecyc, estb, ea0, ea1,
    input logic [1:0] egnt,
    input logic esel1
  );
    vec_t r;
    r.m0c = m0c; r.m0s = m0s; r.m1c = m1c; r.m1s = m1s; r.ack = ack;
    r.ecyc = ecyc; r.estb = estb; r.ea0 = ea0; r.ea1 = ea1;
    r.egnt = egnt; r.esel1 = esel1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic edge_in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errs;
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b1;
    m0_adr = M0_ADR; m0_dat = M0_DAT; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b0;
    m1_adr = M1_ADR; m1_dat = M1_DAT; m1_sel = 4'h3;
    s_ack = 0; s_err = 0; s_rty = 0; s_rdat = RD_DAT;

    // Tie from reset: m0 first, m1 follows with no idle cycle
    vecs.push_back(v(1,1,1,1,0, 0,0,0,0, 2'b00, 0));
    vecs.push_back(v(1,1,1,1,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(1,1,1,1,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(1,1,1,1,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(0,0,1,1,0, 0,0,0,0, 2'b01, 0));
    vecs.push_back(v(0,0,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(0,0,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(0,0,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b10, 1));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b00, 0));
    // Single m0 write, slave acks two cycles after stb
    vecs.push_back(v(1,1,0,0,0, 0,0,0,0, 2'b00, 0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0,0, 2'b01, 0));
    vecs.push_back(v(1,1,0,0,0, 1,1,0,0, 2'b01, 0));
    vecs.push_back(v(1,1,0,0,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b00, 0));
    // Tie again after m0 was last owner: m1 first
    vecs.push_back(v(1,1,1,1,0, 0,0,0,0, 2'b00, 0));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,0,0,0, 0,0,0,0, 2'b10, 1));
    vecs.push_back(v(1,1,0,0,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(1,1,0,0,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(1,1,0,0,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b00, 0));
    // Held tenure: m1 does 4 strobes while m0 waits
    vecs.push_back(v(0,0,1,1,0, 0,0,0,0, 2'b00, 0));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,1,1,1, 1,1,0,1, 2'b10, 1));
    vecs.push_back(v(1,1,0,0,0, 0,0,0,0, 2'b10, 1));
    vecs.push_back(v(1,1,0,0,1, 1,1,1,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b01, 0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0, 2'b00, 0));

    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {s_cyc, s_stb, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty, grant, tcnt},
        '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      edge_in();
      m0_cyc = vecs[i].m0c; m0_stb = vecs[i].m0s;
      m1_cyc = vecs[i].m1c; m1_stb = vecs[i].m1s;
      s_ack = vecs[i].ack;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {s_cyc, s_stb, m0_ack, m1_ack, grant, s_adr, s_wdat, s_we, s_sel},
          {vecs[i].ecyc, vecs[i].estb, vecs[i].ea0, vecs[i].ea1, vecs[i].egnt,
           vecs[i].esel1 ? {M1_ADR, M1_DAT, 1'b0, 4'h3}
                         : {M0_ADR, M0_DAT, 1'b1, 4'hF}});
      chk($sformatf("vec%0d_err", i), {m0_err, m1_err, m0_rty, m1_rty}, '0);
    end
    chk("rdata_bcast", {m0_rdat, m1_rdat}, {RD_DAT, RD_DAT});

    // Watchdog: stb seen by slave from cycle 1, err due in cycle 1+TO
    edge_in();
    m0_cyc = 1; m0_stb = 1; s_ack = 0;
    @(negedge clk);
    for (int c = 1; c <= TO + 1; c++) begin
      edge_in();
      @(negedge clk);
      chk($sformatf("wd_c%0d", c), {m0_err, s_stb, m1_err},
          {c == TO + 1, c != TO + 1, 1'b0});
    end
    chk("wd_tcnt1", tcnt, 8'd1);
    edge_in();
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);

    // Slave acks in the last cycle before the watchdog fires
    edge_in();
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    for (int c = 1; c <= TO + 1; c++) begin
      edge_in();
      s_ack = (c == TO);
      if (c == TO + 1) m0_stb = 0;
      @(negedge clk);
      if (c == TO)
        chk("coll_ack", {m0_ack, m0_err}, 2'b10);
      if (c == TO + 1)
        chk("coll_after", {m0_ack, m0_err, tcnt}, {2'b00, 8'd1});
    end
    edge_in();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    @(negedge clk);

    // 299 more timeouts on a held strobe: count saturates at 255
    edge_in();
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    errs = 0;
    for (int c = 1; c <= 299 * (TO + 1); c++) begin
      edge_in();
      @(negedge clk);
      if (m0_err) errs++;
    end
    chk("sat_errs", 32'(errs), 32'd299);
    chk("sat_tcnt", tcnt, 8'd255);
    edge_in();
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);

    // Async reset mid-strobe while m1 owns the bus
    edge_in();
    m1_cyc = 1; m1_stb = 1;
    edge_in();
    @(negedge clk);
    chk("pre_rst", {s_cyc, s_stb, grant}, {2'b11, 2'b10});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {s_cyc, s_stb, grant, tcnt}, '0);
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    @(negedge clk);
    chk("late_ack", {m0_ack, m1_ack, m0_err, m1_err}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tie", {grant, m1_ack}, {2'b01, 1'b0});
    edge_in();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
